// File: rtl/prbs_burst_if.sv
// prbs_burst_if: control, status and bit-stream signals of the PRBS burst sequencer
interface prbs_burst_if #(parameter int LEN_W = 8);
    logic             start;
    logic             cont;
    logic [3:0]       seed_in;
    logic [LEN_W-1:0] len_in;
    logic             abort;
    logic             bit_out;
    logic             bit_valid;
    logic             bit_ready;
    logic             busy;
    logic             done;
    logic             aborted;
    logic             seed_err;
    logic [LEN_W-1:0] count;
    modport master (
        output start, cont, seed_in, len_in, abort, bit_ready,
        input  bit_out, bit_valid, busy, done, aborted, seed_err, count
    );
    modport slave (
        input  start, cont, seed_in, len_in, abort, bit_ready,
        output bit_out, bit_valid, busy, done, aborted, seed_err, count
    );
endinterface

// File: rtl/prbs_burst_ctrl.sv
// prbs_burst_ctrl: emits a programmed-length burst of x^4+x^3+1 PRBS bits over valid/ready
module prbs_burst_ctrl #(parameter int LEN_W = 8) (
    input logic         clk,
    input logic         rst,
    prbs_burst_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state, state_nx;
    logic [3:0]       lfsr;
    logic [LEN_W-1:0] len, count, count_inc;
    logic             xfer, ab_q, serr, accept;
    assign accept    = state == IDLE && bus.start;
    assign xfer      = state == RUN && bus.bit_ready;
    assign count_inc = count + 1'b1;
    always_ff @(posedge clk)
        state <= rst ? IDLE : state_nx;
    always_comb begin
        state_nx = state;
        if (accept)
            state_nx = bus.len_in == '0 ? DONE : RUN;
        else if (state == RUN && (bus.abort || (xfer && count_inc == len)))
            state_nx = DONE;
        else if (state == DONE)
            state_nx = IDLE;
    end
    // A zero seed would lock the LFSR, so it is replaced by all-ones and flagged.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr  <= 4'hF;
            len   <= '0;
            count <= '0;
            serr  <= 1'b0;
            ab_q  <= 1'b0;
        end else begin
            ab_q <= state == RUN && bus.abort;
            if (accept) begin
                len   <= bus.len_in;
                count <= '0;
                serr  <= !bus.cont && bus.seed_in == 4'h0;
                if (!bus.cont)
                    lfsr <= bus.seed_in == 4'h0 ? 4'hF : bus.seed_in;
            end else if (xfer) begin
                count <= count_inc;
                lfsr  <= {lfsr[0] ^ lfsr[1], lfsr[3], lfsr[2], lfsr[1]};
            end
        end
    end
    assign bus.bit_out   = lfsr[0];
    assign bus.bit_valid = state == RUN;
    assign bus.busy      = state == RUN;
    assign bus.done      = state == DONE;
    assign bus.aborted   = ab_q;
    assign bus.seed_err  = serr;
    assign bus.count     = count;
endmodule
